// File: rtl/iz_param_serializer.sv
// rtl/iz_param_serializer.sv - serializes the a/b/c/d IZ parameter words onto the load_mode/serial_data pair
module iz_param_serializer #(
  parameter int PARAM_WIDTH = 16,
  parameter int NUM_PARAMS  = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic [PARAM_WIDTH-1:0] param_a,
  input  logic [PARAM_WIDTH-1:0] param_b,
  input  logic [PARAM_WIDTH-1:0] param_c,
  input  logic [PARAM_WIDTH-1:0] param_d,
  output logic                   load_mode,
  output logic                   serial_data,
  output logic                   busy,
  output logic                   done
);

  // The port list carries four words, so the frame is always a, b, c, d.
  localparam int FRAME_W = NUM_PARAMS * PARAM_WIDTH;
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [FRAME_W-1:0] shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  // Frame sequencer: every register, outputs included, advances only on enabled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      load_mode   <= 1'b0;
      serial_data <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (enable) begin
      case (state)
        // DONE behaves like IDLE for start so back-to-back frames lose no cycle.
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            shreg       <= {param_a, param_b, param_c, param_d};
            serial_data <= param_a[PARAM_WIDTH-1];
            load_mode   <= 1'b1;
            busy        <= 1'b1;
            bit_cnt     <= '0;
            state       <= S_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
            bit_cnt     <= '0;
            if (GAP_CYCLES == 0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_GAP;
            end
          end else begin
            // serial_data already shows shreg's MSB; present the one below it.
            shreg       <= shreg << 1;
            serial_data <= shreg[FRAME_W-2];
            bit_cnt     <= bit_cnt + BIT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iz_param_serializer.sv
// tb/tb_iz_param_serializer.sv - scoreboard bench for iz_param_serializer
module tb_iz_param_serializer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        start;
  logic [15:0] param_a, param_b, param_c, param_d;
  logic        load_mode, serial_data, busy, done;

  iz_param_serializer #(.PARAM_WIDTH(16), .NUM_PARAMS(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .param_a(param_a), .param_b(param_b), .param_c(param_c), .param_d(param_d),
    .load_mode(load_mode), .serial_data(serial_data), .busy(busy), .done(done)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  int          exp_done = 0;
  int          done_seen = 0;
  bit          stall_mode = 0;
  logic [63:0] last_frame = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Enable generator: free-running, or random stalls when stall_mode is set.
  always begin
    @(posedge clk);
    #2;
    enable = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: loader model plus timing checks, sampled on the falling edge.
  logic [63:0] asm_sr = '0;
  int          run = 0;
  int          busy_cnt = 0;
  bit          acc_pend = 0;
  bit          have_prev = 0;
  bit          prev_en = 0;
  bit          prev_done = 0;
  logic [3:0]  prev_out = '0;

  always @(negedge clk) begin
    if (!reset) begin
      run = 0; busy_cnt = 0; acc_pend = 0; have_prev = 0; prev_done = 0;
    end else begin
      if (acc_pend) begin
        check("first_bit_latency", 64'({load_mode, busy}), 64'h3);
        acc_pend = 0;
      end
      if (have_prev && !prev_en)
        check("stall_hold", 64'({load_mode, serial_data, busy, done}), 64'(prev_out));
      if (done && !prev_done) begin
        done_seen++;
        check("busy_cycles", 64'(busy_cnt), 64'd66);
        busy_cnt = 0;
      end
      if (!load_mode && run != 0) begin
        check("load_mode_cycles", 64'(run), 64'd64);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL frame_unexpected: got %h, expected no frame", asm_sr);
        end else begin
          check("frame_bits", asm_sr, exp_q.pop_front());
        end
        last_frame = asm_sr;
        run = 0;
      end
      if (enable) begin
        if (load_mode) begin
          asm_sr = {asm_sr[62:0], serial_data};
          run++;
        end
        if (busy) busy_cnt++;
        if (start && !busy) acc_pend = 1;
      end
      prev_en   = enable;
      prev_done = done;
      prev_out  = {load_mode, serial_data, busy, done};
      have_prev = 1;
    end
  end

  task automatic send(input logic [15:0] a, b, c, d, input bit expect_ok);
    bit acc;
    bit en_s;
    acc = 0;
    param_a = a; param_b = b; param_c = c; param_d = d;
    start = 1'b1;
    if (expect_ok) begin
      exp_q.push_back({a, b, c, d});
      exp_done++;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      en_s = enable && !busy;
      @(posedge clk);
      #2;
      if (en_s) begin
        acc = 1;
        break;
      end
    end
    start = 1'b0;
    check("start_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_timeout", 64'(seen), 64'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b1; start = 1'b0;
    param_a = '0; param_b = '0; param_c = '0; param_d = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({load_mode, serial_data, busy, done}), 64'h0);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("idle_outputs", 64'({load_mode, serial_data, busy, done}), 64'h0);

    // Basic frame
    send(16'h0002, 16'h0033, 16'hFFC1, 16'h0008, 1);
    wait_done();

    // Enable stalls, same frame
    stall_mode = 1;
    send(16'h0002, 16'h0033, 16'hFFC1, 16'h0008, 1);
    wait_done();
    stall_mode = 0;
    repeat (2) @(posedge clk);
    #2;

    // Start while busy: at bit 20 and during the gap
    send(16'h1357, 16'h2468, 16'h8001, 16'h7FFE, 1);
    repeat (19) @(posedge clk);
    #2; start = 1'b1;
    @(posedge clk);
    #2; start = 1'b0;
    repeat (44) @(posedge clk);
    #2; start = 1'b1;
    @(posedge clk);
    #2; start = 1'b0;
    wait_done();

    // Reset mid-frame, asynchronous
    send(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 0);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 64'({load_mode, serial_data, busy, done}), 64'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    send(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, 1);
    wait_done();

    // Input change after capture
    send(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1);
    @(posedge clk);
    #2;
    param_a = 16'hAAAA;
    wait_done();

    // End-to-end loader words
    send(16'h0005, 16'h0010, 16'hFFBF, 16'h0020, 1);
    wait_done();
    check("loader_a", 64'(last_frame[63:48]), 64'h0005);
    check("loader_b", 64'(last_frame[47:32]), 64'h0010);
    check("loader_c", 64'(last_frame[31:16]), 64'hFFBF);
    check("loader_d", 64'(last_frame[15:0]),  64'h0020);

    repeat (5) @(posedge clk);
    #2;
    check("done_pulse_count", 64'(done_seen), 64'(exp_done));
    check("frames_outstanding", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
